// File: rtl/ncl4_sync_sink_if.sv
// Handshake bundle between a quad-rail NCL pipeline tail and the
// synchronous sink: rails, completion, and the ready/valid FIFO head.
interface ncl4_sync_sink_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    A;
  logic          ACOMP;
  logic [1:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          err;

  modport master (
    output A,
    output out_ready,
    input  ACOMP,
    input  out_data,
    input  out_valid,
    input  count,
    input  err
  );

  modport slave (
    input  A,
    input  out_ready,
    output ACOMP,
    output out_data,
    output out_valid,
    output count,
    output err
  );
endinterface

// File: rtl/ncl4_sync_sink.sv
// Clocked terminator for a four-rail NCL pipeline: synchronizes rails,
// runs the DATA/NULL completion handshake and buffers decoded values.
module ncl4_sync_sink #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             init,
  ncl4_sync_sink_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    p_q;
  logic [3:0]    s;
  logic          stable;
  logic          onehot;
  logic          multi;
  logic [1:0]    idx;

  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, can_push;

  assign s      = sync_q[SYNC_STAGES-1];
  assign stable = (s == p_q);
  assign multi  = (s & (s - 4'd1)) != 4'd0;
  assign onehot = (s != 4'd0) && !multi;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= bus.A;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      p_q <= s;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (s[i]) idx = 2'(i);
  end

  assign pop      = (count_q != '0) && bus.out_ready;
  assign can_push = (count_q < CW'(DEPTH)) || pop;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      WAIT_DATA: begin
        if (stable && onehot && can_push) begin
          push    = 1'b1;
          state_d = WAIT_NULL;
        end else if (stable && multi) begin
          // illegal wavefront: flag it and drain it like a normal one
          err_d   = 1'b1;
          state_d = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (stable && s == 4'd0)
          state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= WAIT_DATA;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= idx;
  end

  assign bus.ACOMP     = (state_q == WAIT_NULL);
  assign bus.out_data  = mem_q[rd_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.err       = err_q;
endmodule
